// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - mode encodings and counter-width helper for univ_shift_reg
package usr_pkg;

    localparam logic [2:0] USR_HOLD = 3'b000;
    localparam logic [2:0] USR_SHR  = 3'b001;
    localparam logic [2:0] USR_SHL  = 3'b010;
    localparam logic [2:0] USR_ROR  = 3'b011;
    localparam logic [2:0] USR_ROL  = 3'b100;
    localparam logic [2:0] USR_LOAD = 3'b101;
    localparam logic [2:0] USR_SCLR = 3'b110;
    localparam logic [2:0] USR_RSVD = 3'b111;

    // Bits needed to hold a fill count from 0 up to and including width
    function automatic int usr_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/usr_fill_cnt.sv
// rtl/usr_fill_cnt.sv - saturating fill counter producing count, full and done
module usr_fill_cnt
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = usr_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    input  logic             set_max,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             done_q, done_d;

    // Next count: clear wins, then load-to-max, then a saturating increment;
    // done fires only on the increment that reaches the top.
    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (clr_cnt) begin
            count_d = '0;
        end else if (set_max) begin
            count_d = CNT_MAX;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
            done_d  = (count_q == CNT_MAX - CNT_W'(1));
        end
        full_d = (count_d == CNT_MAX);
    end

    // Counter state registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_q <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign full  = full_q;
    assign done  = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register / deserialiser; optional compare via USR_MATCH_EN
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = usr_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             done
`ifdef USR_MATCH_EN
    ,
    input  logic [WIDTH-1:0] pattern,
    output logic             match
`endif
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             cnt_inc, cnt_set_max, cnt_clr;

    // Datapath mux: next word for each mode; reserved code and en=0 hold
    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                USR_SHR:  q_d = {sin_r, q_q[WIDTH-1:1]};
                USR_SHL:  q_d = {q_q[WIDTH-2:0], sin_l};
                USR_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                USR_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                USR_LOAD: q_d = d;
                USR_SCLR: q_d = '0;
                default:  q_d = q_q;
            endcase
        end
    end

    // Word register with asynchronous active-low clear
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) q_q <= '0;
        else      q_q <= q_d;
    end

    assign cnt_inc     = en && ((mode == USR_SHR) || (mode == USR_SHL));
    assign cnt_set_max = en && (mode == USR_LOAD);
    assign cnt_clr     = en && (mode == USR_SCLR);

    usr_fill_cnt #(.WIDTH(WIDTH)) u_fill_cnt (
        .clk     (clk),
        .clr     (clr),
        .inc     (cnt_inc),
        .set_max (cnt_set_max),
        .clr_cnt (cnt_clr),
        .count   (count),
        .full    (full),
        .done    (done)
    );

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];

`ifdef USR_MATCH_EN
    logic match_q, match_d;

    // Compare against the next word so match lines up with q
    always_comb begin
        match_d = (q_d == pattern);
    end

    // Match flag updates every cycle, independent of en
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) match_q <= 1'b0;
        else      match_q <= match_d;
    end

    assign match = match_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg (WIDTH=4)
module tb_univ_shift_reg;

    localparam int W = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic          sin_r = 1'b0;
    logic          sin_l = 1'b0;
    logic [W-1:0]  d = '0;
    logic [W-1:0]  q;
    logic          sout_r, sout_l;
    logic [CW-1:0] count;
    logic          full, done;
`ifdef USR_MATCH_EN
    logic [W-1:0]  pattern = 4'b1010;
    logic          match;
`endif

    int errs = 0;
    int checks = 0;

    int m_q = 0;
    int m_cnt = 0;
    bit m_done = 0;
    bit m_match = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk    (clk),
        .clr    (clr),
        .en     (en),
        .mode   (mode),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .d      (d),
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .count  (count),
        .full   (full),
        .done   (done)
`ifdef USR_MATCH_EN
        ,
        .pattern(pattern),
        .match  (match)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"}, 32'(q), 32'(m_q));
        check({tag, ".count"}, 32'(count), 32'(m_cnt));
        check({tag, ".full"}, 32'(full), 32'(m_cnt == W));
        check({tag, ".done"}, 32'(done), 32'(m_done));
        check({tag, ".sout_r"}, 32'(sout_r), 32'(m_q % 2));
        check({tag, ".sout_l"}, 32'(sout_l), 32'(m_q / (1 << (W - 1))));
`ifdef USR_MATCH_EN
        check({tag, ".match"}, 32'(match), 32'(m_match));
`endif
    endtask

    // Reference behaviour written from the mode table using integer arithmetic
    task automatic model_step(input bit e, input int md, input bit sr, input bit sl, input int dd);
        int full_word;
        full_word = (1 << W) - 1;
        m_done = 0;
        if (e) begin
            case (md)
                1, 2: begin
                    if (md == 1) m_q = (m_q / 2) + (sr ? (1 << (W - 1)) : 0);
                    else         m_q = ((m_q * 2) + (sl ? 1 : 0)) % (1 << W);
                    if (m_cnt < W) begin
                        m_cnt = m_cnt + 1;
                        if (m_cnt == W) m_done = 1;
                    end
                end
                3: m_q = (m_q / 2) + ((m_q % 2) * (1 << (W - 1)));
                4: m_q = ((m_q * 2) % (1 << W)) + (m_q / (1 << (W - 1)));
                5: begin m_q = dd & full_word; m_cnt = W; end
                6: begin m_q = 0; m_cnt = 0; end
                default: ;
            endcase
        end
`ifdef USR_MATCH_EN
        m_match = (m_q == int'(pattern));
`endif
    endtask

    task automatic cyc(input string tag, input bit e, input int md, input bit sr, input bit sl, input int dd);
        @(negedge clk);
        en = e; mode = md[2:0]; sin_r = sr; sin_l = sl; d = dd[W-1:0];
        model_step(e, md, sr, sl, dd);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        m_q = 0; m_cnt = 0; m_done = 0; m_match = 0;
    endtask

    // Pulse clr low mid-cycle and confirm the clear lands without a clock edge
    task automatic mid_reset(input string tag);
        @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1;
        clr = 1'b1;
    endtask

    initial begin
        // Reset held with a load pending: outputs clear immediately
        #1;
        en = 1'b1; mode = 3'b101; d = 4'hF; clr = 1'b0;
        #2;
        model_reset();
        check_all("reset");
        @(negedge clk);
        en = 1'b0;
        clr = 1'b1;

        // Deserialise 1,0,1,1 through SHR
        cyc("shr1", 1, 1, 1, 0, 0);
        check("shr1.q_const", 32'(q), 32'h8);
        cyc("shr2", 1, 1, 0, 0, 0);
        cyc("shr3", 1, 1, 1, 0, 0);
        cyc("shr4", 1, 1, 1, 0, 0);
        check("shr4.q_const", 32'(q), 32'hD);
        check("shr4.done_const", 32'(done), 32'h1);
        cyc("shr5", 1, 1, 0, 0, 0);
        check("shr5.q_const", 32'(q), 32'h6);
        check("shr5.done_const", 32'(done), 32'h0);

        // Load, rotate right then left
        cyc("load", 1, 5, 0, 0, 9);
        cyc("ror", 1, 3, 0, 0, 0);
        check("ror.q_const", 32'(q), 32'hC);
        cyc("rol", 1, 4, 0, 0, 0);
        cyc("shl", 1, 2, 0, 0, 0);
        check("shl.q_const", 32'(q), 32'h2);

        // Enable low blocks a load; then clear; then reserved code holds
        cyc("en0", 0, 5, 0, 0, 6);
        cyc("sclr", 1, 6, 0, 0, 0);
        cyc("rsvd", 1, 7, 1, 1, 15);

        // Async clear between two shifts
        cyc("pre_rst", 1, 1, 1, 0, 0);
        mid_reset("mid_rst");
        cyc("post_rst", 1, 1, 1, 0, 0);

`ifdef USR_MATCH_EN
        cyc("ld_match", 1, 5, 0, 0, 10);
        check("ld_match.const", 32'(match), 32'h1);
        cyc("shl_nomatch", 1, 2, 0, 0, 0);
        check("shl_nomatch.const", 32'(match), 32'h0);
`endif

        // Randomised traffic biased toward shifts, with occasional async clears
        for (int i = 0; i < 400; i++) begin
            int r;
            int md;
            r = int'($urandom_range(0, 15));
            md = (r < 8) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) mid_reset("rnd_rst");
            else cyc("rnd", ($urandom_range(0, 7) != 0), md, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
